// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Package : tdc_pkg
// Brief   : Shared types, widths and helpers for the TDC Hamming-weight
//           statistics engine.
// Rev     : 1.0  initial release
// ============================================================================
package tdc_pkg;

    localparam int c_n     = 64;
    localparam int c_l_max = 8;
    localparam int c_l_w   = 4;

    function automatic int hw_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int sum_width(input int n, input int l_max);
        return hw_width(n) + l_max;
    endfunction

    localparam int c_hw_w  = hw_width(c_n);
    localparam int c_sum_w = sum_width(c_n, c_l_max);
    localparam int c_cnt_w = c_l_max + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } tdc_state_t;

    typedef struct packed {
        logic [c_sum_w-1:0] sum;
        logic [c_hw_w-1:0]  min;
        logic [c_hw_w-1:0]  max;
        logic [c_cnt_w-1:0] cnt;
    } tdc_stat_t;

    localparam tdc_stat_t c_stat_init = '{sum: '0, min: '1, max: '0, cnt: '0};

    // A channel is full once it holds exactly 2^l samples.
    function automatic logic stat_full(input tdc_stat_t s, input logic [c_l_w-1:0] l);
        return s.cnt == (c_cnt_w'(1) << l);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdc_ch_stat.sv
`default_nettype none
// ============================================================================
// Module : tdc_ch_stat
// Brief  : Single-channel accumulator of sum, min, max and sample count.
// Rev    : 1.0  initial release
// ============================================================================
module tdc_ch_stat
    import tdc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [c_hw_w-1:0] hw,
    input  logic [c_l_w-1:0]  l,
    output tdc_stat_t         stat
);

    tdc_stat_t r_stat;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_stat <= c_stat_init;
        end else if (accept && !stat_full(r_stat, l)) begin
            r_stat.sum <= r_stat.sum + c_sum_w'(hw);
            r_stat.cnt <= r_stat.cnt + c_cnt_w'(1);
            if (hw < r_stat.min) r_stat.min <= hw;
            if (hw > r_stat.max) r_stat.max <= hw;
        end
    end

    assign stat = r_stat;

endmodule
`default_nettype wire

// File: rtl/tdc_hw_accum.sv
`default_nettype none
// ============================================================================
// Module : tdc_hw_accum
// Brief  : Multi-channel Hamming-weight averager: collects 2^L samples per
//          channel and streams out sum, floor mean, min and max per channel.
// Rev    : 1.0  initial release
// ============================================================================
module tdc_hw_accum
    import tdc_pkg::*;
#(
    parameter  int N      = c_n,
    parameter  int N_CH   = 4,
    parameter  int L_MAX  = c_l_max,
    parameter  int DROP_W = 8,
    localparam int HW_W   = hw_width(N),
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int SUM_W  = sum_width(N, L_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [3:0]        log2_samples,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [HW_W-1:0]   in_hw,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [SUM_W-1:0]  out_sum,
    output logic [HW_W-1:0]   out_mean,
    output logic [HW_W-1:0]   out_min,
    output logic [HW_W-1:0]   out_max,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              range_err
);

    localparam logic [3:0] c_l_clamp = 4'(L_MAX);

    tdc_state_t        r_state;
    logic [3:0]        r_l;
    logic [CH_W-1:0]   r_ptr;
    logic [DROP_W-1:0] r_drop;
    logic              r_range_err;
    logic              r_done;
    logic              r_out_valid;
    logic [CH_W-1:0]   r_out_ch;
    logic [SUM_W-1:0]  r_out_sum;
    logic [HW_W-1:0]   r_out_mean;
    logic [HW_W-1:0]   r_out_min;
    logic [HW_W-1:0]   r_out_max;

    tdc_stat_t         w_stats [N_CH];
    tdc_stat_t         w_sel;
    logic [N_CH-1:0]   w_full;
    logic [N_CH-1:0]   w_accept;
    logic [CH_W:0]     w_ch_ext;
    logic [CH_W-1:0]   w_sel_idx;
    logic              w_in_range;
    logic              w_take;
    logic              w_drop;
    logic              w_clear;
    logic              w_handshake;

    always_comb begin
        w_ch_ext    = {1'b0, in_ch};
        w_in_range  = (w_ch_ext < (CH_W+1)'(N_CH)) && (in_hw <= HW_W'(N));
        w_take      = en && in_valid && (r_state == ST_ACCUM) && w_in_range && !w_full[in_ch];
        w_drop      = en && in_valid && !w_take;
        w_clear     = en && (r_state == ST_IDLE) && start;
        w_handshake = en && r_out_valid && out_ready;
        // Entering DRAIN presents channel 0; each handshake preloads the next one.
        w_sel_idx   = (r_state == ST_DRAIN) ? r_ptr + CH_W'(1) : '0;
        w_sel       = w_stats[w_sel_idx];
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_accept[i] = w_take && (in_ch == CH_W'(i));
        assign w_full[i]   = stat_full(w_stats[i], r_l);

        tdc_ch_stat u_ch_stat (
            .clk    (clk),
            .rst    (rst),
            .clear  (w_clear),
            .accept (w_accept[i]),
            .hw     (in_hw),
            .l      (r_l),
            .stat   (w_stats[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_l         <= '0;
            r_ptr       <= '0;
            r_drop      <= '0;
            r_range_err <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_sum   <= '0;
            r_out_mean  <= '0;
            r_out_min   <= '0;
            r_out_max   <= '0;
        end else if (en) begin
            r_done <= 1'b0;
            if (w_drop && (r_drop != '1)) r_drop <= r_drop + DROP_W'(1);

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_l         <= (log2_samples > c_l_clamp) ? c_l_clamp : log2_samples;
                        r_range_err <= 1'b0;
                        r_state     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid && !w_in_range) r_range_err <= 1'b1;
                    // Judged on registered counts, so the filling sample is already summed.
                    if (&w_full) begin
                        r_state     <= ST_DRAIN;
                        r_ptr       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_ch    <= '0;
                        r_out_sum   <= w_sel.sum;
                        r_out_mean  <= HW_W'(w_sel.sum >> r_l);
                        r_out_min   <= w_sel.min;
                        r_out_max   <= w_sel.max;
                    end
                end
                ST_DRAIN: begin
                    if (w_handshake) begin
                        if (r_ptr == CH_W'(N_CH-1)) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_ptr      <= r_ptr + CH_W'(1);
                            r_out_ch   <= r_ptr + CH_W'(1);
                            r_out_sum  <= w_sel.sum;
                            r_out_mean <= HW_W'(w_sel.sum >> r_l);
                            r_out_min  <= w_sel.min;
                            r_out_max  <= w_sel.max;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_sum   = r_out_sum;
    assign out_mean  = r_out_mean;
    assign out_min   = r_out_min;
    assign out_max   = r_out_max;
    assign drop_cnt  = r_drop;
    assign range_err = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_tdc_hw_accum.sv
`default_nettype none
// ============================================================================
// Module : tb_tdc_hw_accum
// Brief  : Self-checking bench for tdc_hw_accum against a sample-list model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tdc_hw_accum;

    localparam int N      = 64;
    localparam int N_CH   = 4;
    localparam int L_MAX  = 8;
    localparam int DROP_W = 8;
    localparam int HW_W   = 7;
    localparam int CH_W   = 2;
    localparam int SUM_W  = 15;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              rst, en, start, in_valid, out_ready;
    logic [3:0]        log2_samples;
    logic [CH_W-1:0]   in_ch;
    logic [HW_W-1:0]   in_hw;
    logic              busy, done, out_valid, range_err;
    logic [CH_W-1:0]   out_ch;
    logic [SUM_W-1:0]  out_sum;
    logic [HW_W-1:0]   out_mean, out_min, out_max;
    logic [DROP_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    tdc_hw_accum #(.N(N), .N_CH(N_CH), .L_MAX(L_MAX), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .log2_samples(log2_samples),
        .in_valid(in_valid), .in_ch(in_ch), .in_hw(in_hw), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_sum(out_sum),
        .out_mean(out_mean), .out_min(out_min), .out_max(out_max),
        .drop_cnt(drop_cnt), .range_err(range_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: per-channel lists of accepted samples plus run flags.
    bit m_running, m_draining, m_range, m_done;
    int m_l, m_drop, m_exp_ch;
    int m_q [N_CH][$];
    bit use_fixed;
    int fx_sum [N_CH], fx_mean [N_CH], fx_min [N_CH], fx_max [N_CH];
    int done_rises;
    bit prev_done;

    typedef struct { int ch; int hw; } smp_t;
    smp_t stim_q [$];

    function automatic bit all_full();
        for (int c = 0; c < N_CH; c++)
            if (m_q[c].size() < (1 << m_l)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit full_pre, inr;
        if (rst) begin
            m_running = 0; m_draining = 0; m_range = 0; m_done = 0;
            m_drop = 0; m_exp_ch = 0;
            for (int c = 0; c < N_CH; c++) m_q[c].delete();
            return;
        end
        if (!en) return;
        full_pre = all_full();
        if (in_valid) begin
            inr = (int'(in_ch) < N_CH) && (int'(in_hw) <= N);
            if (m_running && !m_draining && inr && m_q[in_ch].size() < (1 << m_l))
                m_q[in_ch].push_back(int'(in_hw));
            else if (m_drop < DROP_MAX)
                m_drop++;
            if (m_running && !m_draining && !inr) m_range = 1;
        end
        m_done = 0;
        if (!m_running) begin
            if (start) begin
                m_l = (int'(log2_samples) > L_MAX) ? L_MAX : int'(log2_samples);
                for (int c = 0; c < N_CH; c++) m_q[c].delete();
                m_range = 0;
                m_running = 1;
            end
        end else if (!m_draining) begin
            if (full_pre) begin m_draining = 1; m_exp_ch = 0; end
        end else if (out_ready) begin
            m_exp_ch++;
            if (m_exp_ch == N_CH) begin m_draining = 0; m_running = 0; m_done = 1; end
        end
    endtask

    task automatic check_all();
        int s, mn, mx, mean;
        check_eq("busy", 64'(busy), 64'(m_running));
        check_eq("out_valid", 64'(out_valid), 64'(m_draining));
        check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        check_eq("range_err", 64'(range_err), 64'(m_range));
        check_eq("done", 64'(done), 64'(m_done));
        if (done && !prev_done) done_rises++;
        prev_done = done;
        if (m_draining) begin
            if (use_fixed) begin
                s = fx_sum[m_exp_ch]; mean = fx_mean[m_exp_ch];
                mn = fx_min[m_exp_ch]; mx = fx_max[m_exp_ch];
            end else begin
                s = 0; mn = N + 1; mx = -1;
                foreach (m_q[m_exp_ch][k]) begin
                    s += m_q[m_exp_ch][k];
                    if (m_q[m_exp_ch][k] < mn) mn = m_q[m_exp_ch][k];
                    if (m_q[m_exp_ch][k] > mx) mx = m_q[m_exp_ch][k];
                end
                mean = s / (1 << m_l);
            end
            check_eq("out_ch", 64'(out_ch), 64'(m_exp_ch));
            check_eq("out_sum", 64'(out_sum), 64'(s));
            check_eq("out_mean", 64'(out_mean), 64'(mean));
            check_eq("out_min", 64'(out_min), 64'(mn));
            check_eq("out_max", 64'(out_max), 64'(mx));
        end
    endtask

    task automatic cyc(input bit e, input bit v, input int c, input int h, input bit s, input bit r);
        en = e; in_valid = v; in_ch = CH_W'(c); in_hw = HW_W'(h); start = s; out_ready = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 1, 0, 5, 1, 1);
        rst = 1'b0;
        check_eq("rst_out_ch", 64'(out_ch), 64'(0));
        check_eq("rst_out_sum", 64'(out_sum), 64'(0));
        check_eq("rst_out_mean", 64'(out_mean), 64'(0));
        check_eq("rst_out_min", 64'(out_min), 64'(0));
        check_eq("rst_out_max", 64'(out_max), 64'(0));
    endtask

    // ready_mode: 0 always ready, 1 random, 2 hold off for 5 drain cycles.
    task automatic run(input int lreq, input int ready_mode, input bit rand_fill,
                       input int en_off, input bit stop_in_drain);
        int hold = 0, budget = 0;
        bit r, e, v, s;
        int c, h;
        smp_t sm;
        done_rises = 0;
        log2_samples = 4'(lreq);
        cyc(1, 1, 0, 5, 1, 0);
        for (int i = 0; i < en_off; i++) cyc(0, 1, 1, 9, 0, 1);
        while (m_running && budget < 6000 && !(stop_in_drain && m_draining)) begin
            budget++;
            if (ready_mode == 0) r = 1;
            else if (ready_mode == 1) r = $urandom_range(0, 1) == 1;
            else if (m_draining && hold < 5) begin r = 0; hold++; end
            else r = 1;
            if (stim_q.size() > 0 && !m_draining) begin
                sm = stim_q.pop_front();
                cyc(1, 1, sm.ch, sm.hw, 0, r);
            end else if (rand_fill) begin
                e = ($urandom % 8) != 0;
                v = ($urandom % 4) != 0;
                s = ($urandom % 16) == 0;
                c = $urandom_range(0, N_CH - 1);
                h = (($urandom % 16) == 0) ? $urandom_range(N + 1, 127) : $urandom_range(0, N);
                cyc(e, v, c, h, s, r);
            end else begin
                cyc(1, 0, 0, 0, 0, r);
            end
        end
        if (stop_in_drain) begin
            check_eq("reach_drain", 64'(m_draining), 64'(1));
        end else begin
            check_eq("run_timeout", 64'(m_running), 64'(0));
            cyc(1, 0, 0, 0, 0, 0);
            check_eq("done_pulses", 64'(done_rises), 64'(1));
        end
    endtask

    task automatic push(input int c, input int h);
        smp_t sm;
        sm.ch = c; sm.hw = h;
        stim_q.push_back(sm);
    endtask

    task automatic set_fx(input int c, input int s, input int mean, input int mn, input int mx);
        fx_sum[c] = s; fx_mean[c] = mean; fx_min[c] = mn; fx_max[c] = mx;
    endtask

    initial begin
        int d0;
        rst = 0; en = 0; start = 0; in_valid = 0; out_ready = 0;
        in_ch = '0; in_hw = '0; log2_samples = '0;
        use_fixed = 0; prev_done = 0;

        // Reset, then three samples while idle
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 5, 0, 0);
        check_eq("idle_drops", 64'(drop_cnt), 64'(3));

        // Basic run L=2 with back-pressure on channel 0
        foreach (stim_q[i]) ;
        push(0, 10); push(0, 20); push(0, 30); push(0, 40);
        push(1, 1);  push(1, 1);  push(1, 1);  push(1, 1);
        push(2, 0);  push(2, 64); push(2, 0);  push(2, 64);
        push(3, 63); push(3, 62); push(3, 61); push(3, 60);
        set_fx(0, 100, 25, 10, 40);
        set_fx(1, 4, 1, 1, 1);
        set_fx(2, 128, 32, 0, 64);
        set_fx(3, 246, 61, 60, 63);
        use_fixed = 1;
        run(2, 2, 0, 0, 0);
        use_fixed = 0;

        // Overfull channel and out-of-range samples with L=1
        d0 = m_drop;
        push(0, 7); push(0, 9); push(0, 11);
        push(1, 65); push(1, 127); push(1, 3); push(1, 4);
        push(2, 5); push(2, 6); push(3, 0); push(3, 64);
        set_fx(0, 16, 8, 7, 9);
        set_fx(1, 7, 3, 3, 4);
        set_fx(2, 11, 5, 5, 6);
        set_fx(3, 64, 32, 0, 64);
        use_fixed = 1;
        run(1, 0, 0, 0, 0);
        use_fixed = 0;
        // one start-cycle idle drop plus the three rejected samples
        check_eq("overfull_drops", 64'(drop_cnt), 64'(d0 + 4));
        check_eq("range_sticky", 64'(range_err), 64'(1));

        // Enable freeze in ACCUM, then reset in the middle of DRAIN
        run(0, 0, 1, 3, 1);
        do_reset();
        check_eq("mid_rst_valid", 64'(out_valid), 64'(0));
        check_eq("mid_rst_busy", 64'(busy), 64'(0));
        check_eq("mid_rst_drop", 64'(drop_cnt), 64'(0));

        // Drop counter saturation
        for (int i = 0; i < 300; i++) cyc(1, 1, $urandom_range(0, N_CH - 1), $urandom_range(0, N), 0, 0);
        check_eq("drop_sat", 64'(drop_cnt), 64'(255));

        // Randomized runs, then the clamped L=15 run
        do_reset();
        for (int k = 0; k < 4; k++) run($urandom_range(0, 3), 1, 1, 0, 0);
        run(15, 1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
